// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access types, MMIO offsets
// and the access-type decode helper used by the top level.
package dmem_responder_pkg;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   localparam logic [3:0] MMIO_COUNT  = 4'h0;
   localparam logic [3:0] MMIO_CMP    = 4'h4;
   localparam logic [3:0] MMIO_STATUS = 4'h8;
   localparam logic [3:0] MMIO_LED    = 4'hC;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } accSize_e;

   typedef struct packed {
      accSize_e size;
      logic     signExt;
   } access_t;

   // Unlisted type codes fall through to a plain word access.
   function automatic access_t decodeType(input logic [2:0] t);
      access_t a;
      a.size    = SZ_WORD;
      a.signExt = 1'b0;
      case (t)
         DM_HALF:   begin a.size = SZ_HALF; a.signExt = 1'b1; end
         DM_HALF_U: begin a.size = SZ_HALF; a.signExt = 1'b0; end
         DM_BYTE:   begin a.size = SZ_BYTE; a.signExt = 1'b1; end
         DM_BYTE_U: begin a.size = SZ_BYTE; a.signExt = 1'b0; end
         default:   ;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// MMIO page registers: free-running COUNT, CMP, sticky match STATUS and LED,
// plus the timer interrupt derived from STATUS[0].
module dmem_mmio_timer
   import dmem_responder_pkg::*;
#(
   parameter int LED_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic [3:0]       i_off,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_count,
   output logic [31:0]      o_cmp,
   output logic             o_status,
   output logic [LED_W-1:0] o_led,
   output logic             o_irq
);

   logic [31:0]      r_count;
   logic [31:0]      r_cmp;
   logic             r_status;
   logic [LED_W-1:0] r_led;

   // A match on this cycle overrides a simultaneous write-1-to-clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= 32'h0;
         r_cmp    <= 32'hFFFF_FFFF;
         r_status <= 1'b0;
         r_led    <= '0;
      end else begin
         r_count <= r_count + 32'd1;
         if (i_we && i_off == MMIO_CMP) begin
            r_cmp <= i_wdata;
         end
         if (i_we && i_off == MMIO_LED) begin
            r_led <= i_wdata[LED_W-1:0];
         end
         if (r_count == r_cmp) begin
            r_status <= 1'b1;
         end else if (i_we && i_off == MMIO_STATUS && i_wdata[0]) begin
            r_status <= 1'b0;
         end
      end
   end

   assign o_count  = r_count;
   assign o_cmp    = r_cmp;
   assign o_status = r_status;
   assign o_led    = r_led;
   assign o_irq    = r_status;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: address decode, lane steering, load
// extension, the RAM array, the sticky error flag and the MMIO timer page.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
   parameter int          LED_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic             mem_w,
   input  logic             mem_r,
   input  logic [2:0]       dm_type,
   output logic [31:0]      rdata,
   output logic [LED_W-1:0] led,
   output logic             irq_timer,
   output logic             err
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic          r_err;

   access_t       w_acc;
   logic          w_inRam, w_inMmio, w_aligned, w_ramOk, w_mmioOk, w_bad;
   logic [AW-1:0] w_wordIdx;
   logic [31:0]   w_ramWord, w_ramRd, w_mmioRd, w_wlanes;
   logic [15:0]   w_half;
   logic [7:0]    w_byte;
   logic [3:0]    w_be;
   logic [31:0]   w_count, w_cmp;
   logic          w_status;

   assign w_acc     = decodeType(dm_type);
   assign w_inRam   = addr < RAM_BYTES;
   assign w_inMmio  = addr[31:4] == MMIO_BASE[31:4];
   assign w_aligned = (w_acc.size == SZ_BYTE) ||
                      (w_acc.size == SZ_HALF && !addr[0]) ||
                      (w_acc.size == SZ_WORD && addr[1:0] == 2'b00);
   assign w_ramOk   = w_inRam && w_aligned;
   assign w_mmioOk  = w_inMmio && w_acc.size == SZ_WORD && addr[1:0] == 2'b00;
   assign w_bad     = (mem_w || mem_r) && !(w_ramOk || w_mmioOk);
   assign w_wordIdx = addr[AW+1:2];
   assign w_ramWord = r_mem[w_wordIdx];

   // Replicate sub-word store data across lanes; the byte enables pick the target.
   always_comb begin
      w_wlanes = wdata;
      w_be     = 4'b1111;
      case (w_acc.size)
         SZ_BYTE: begin
            w_wlanes = {4{wdata[7:0]}};
            w_be     = 4'b0001 << addr[1:0];
         end
         SZ_HALF: begin
            w_wlanes = {2{wdata[15:0]}};
            w_be     = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_w && w_ramOk) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_wordIdx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      w_half  = addr[1] ? w_ramWord[31:16] : w_ramWord[15:0];
      w_byte  = w_ramWord[{addr[1:0], 3'b000} +: 8];
      w_ramRd = w_ramWord;
      case (w_acc.size)
         SZ_BYTE: w_ramRd = {{24{w_acc.signExt & w_byte[7]}}, w_byte};
         SZ_HALF: w_ramRd = {{16{w_acc.signExt & w_half[15]}}, w_half};
         default: ;
      endcase
   end

   dmem_mmio_timer #(
      .LED_W (LED_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (mem_w && w_mmioOk),
      .i_off    (addr[3:0]),
      .i_wdata  (wdata),
      .o_count  (w_count),
      .o_cmp    (w_cmp),
      .o_status (w_status),
      .o_led    (led),
      .o_irq    (irq_timer)
   );

   always_comb begin
      w_mmioRd = 32'h0;
      case (addr[3:0])
         MMIO_COUNT:  w_mmioRd = w_count;
         MMIO_CMP:    w_mmioRd = w_cmp;
         MMIO_STATUS: w_mmioRd = {31'h0, w_status};
         MMIO_LED:    w_mmioRd = 32'(led);
         default:     ;
      endcase
   end

   assign rdata = !mem_r   ? 32'h0 :
                  w_ramOk  ? w_ramRd :
                  w_mmioOk ? w_mmioRd : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_bad) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, timer/reset
// sequences and randomized traffic against a byte-level reference model.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam logic [31:0] MMIO = 32'hFFFF_0000;
   localparam int          RAMB = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wdata, rdata;
   logic        mem_w, mem_r;
   logic [2:0]  dm_type;
   logic [15:0] led;
   logic        irq_timer, err;

   int nChecks = 0;
   int nFails  = 0;

   logic [7:0]  memModel [RAMB];
   logic [31:0] countM, cmpM, ledM;
   logic        statusM, errM;

   typedef struct {
      logic        w;
      logic        r;
      logic [2:0]  t;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   dmem_responder u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .wdata     (wdata),
      .mem_w     (mem_w),
      .mem_r     (mem_r),
      .dm_type   (dm_type),
      .rdata     (rdata),
      .led       (led),
      .irq_timer (irq_timer),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic int accSize(logic [2:0] t);
      case (t)
         DM_HALF, DM_HALF_U: return 2;
         DM_BYTE, DM_BYTE_U: return 1;
         default:            return 4;
      endcase
   endfunction

   function automatic bit isLegal(logic [2:0] t, logic [31:0] a);
      int s = accSize(t);
      if (a < RAMB) return (a % 32'(s)) == 0;
      if (a >= MMIO && a <= MMIO + 32'd15) return s == 4 && (a % 32'd4) == 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] modelLoad(logic r, logic [2:0] t, logic [31:0] a);
      logic [31:0] v = 32'h0;
      int s = accSize(t);
      if (!r || !isLegal(t, a)) return 32'h0;
      if (a < RAMB) begin
         for (int i = 0; i < s; i++) v[8*i +: 8] = memModel[a + 32'(i)];
         case (t)
            DM_HALF: return {{16{v[15]}}, v[15:0]};
            DM_BYTE: return {{24{v[7]}}, v[7:0]};
            default: return v;
         endcase
      end
      case (a[3:0])
         4'h0:    return countM;
         4'h4:    return cmpM;
         4'h8:    return {31'h0, statusM};
         default: return ledM;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; returns there one cycle later.
   task automatic applyStimulus(input logic w, input logic r, input logic [2:0] t,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] got);
      bit match, legal;
      int s;
      mem_w = w; mem_r = r; dm_type = t; addr = a; wdata = d;
      #1;
      got = rdata;
      checkOutput("rdata", rdata, modelLoad(r, t, a));
      @(posedge clk);
      match = (countM == cmpM);
      legal = isLegal(t, a);
      s     = accSize(t);
      if ((w || r) && !legal) errM = 1'b1;
      if (w && legal) begin
         if (a < RAMB) begin
            for (int i = 0; i < s; i++) memModel[a + 32'(i)] = d[8*i +: 8];
         end else begin
            case (a[3:0])
               4'h4:    cmpM = d;
               4'h8:    if (d[0]) statusM = 1'b0;
               4'hC:    ledM = d & 32'h0000_FFFF;
               default: ;
            endcase
         end
      end
      if (match) statusM = 1'b1;
      countM = countM + 32'd1;
      @(negedge clk);
      checkOutput("err", {31'h0, err}, {31'h0, errM});
      checkOutput("irq_timer", {31'h0, irq_timer}, {31'h0, statusM});
      checkOutput("led", {16'h0, led}, ledM);
   endtask

   task automatic idle(input int n);
      logic [31:0] g;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0, g);
   endtask

   // Asserts reset mid-cycle, checks the asynchronous clear, releases on the next falling edge.
   task automatic doReset();
      mem_w = 1'b0; mem_r = 1'b1; dm_type = DM_WORD; addr = MMIO; wdata = 32'h0;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_led", {16'h0, led}, 32'h0);
      checkOutput("rst_irq", {31'h0, irq_timer}, 32'h0);
      checkOutput("rst_err", {31'h0, err}, 32'h0);
      checkOutput("rst_count", rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      countM = 32'h0; cmpM = 32'hFFFF_FFFF; statusM = 1'b0; ledM = 32'h0; errM = 1'b0;
   endtask

   initial begin
      logic [31:0] g;
      logic [2:0]  irqSeq;
      logic [31:0] c;
      int          cat;
      logic [31:0] ra;

      rst_n = 1'b0; mem_w = 1'b0; mem_r = 1'b0; dm_type = DM_WORD; addr = 32'h0; wdata = 32'h0;
      @(negedge clk);
      doReset();

      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b0, DM_WORD, 32'(i * 4), 32'h0, g);

      // Reset in the middle of a run, then a plain word round trip.
      applyStimulus(1'b1, 1'b0, DM_WORD, MMIO + 32'hC, 32'h0000_A5A5, g);
      doReset();
      applyStimulus(1'b1, 1'b0, DM_WORD, 32'h10, 32'h1234_5678, g);
      applyStimulus(1'b0, 1'b1, DM_WORD, 32'h10, 32'h0, g);
      checkOutput("lw_after_reset", g, 32'h1234_5678);

      vecs[0]  = '{1'b1, 1'b0, DM_WORD,   32'h20, 32'h1122_3344, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, DM_BYTE,   32'h21, 32'h0000_00AB, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, DM_HALF,   32'h22, 32'h0000_BEEF, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, DM_WORD,   32'h20, 32'h0,         32'hBEEF_AB44};
      vecs[4]  = '{1'b0, 1'b1, DM_BYTE,   32'h21, 32'h0,         32'hFFFF_FFAB};
      vecs[5]  = '{1'b0, 1'b1, DM_BYTE_U, 32'h21, 32'h0,         32'h0000_00AB};
      vecs[6]  = '{1'b0, 1'b1, DM_HALF,   32'h22, 32'h0,         32'hFFFF_BEEF};
      vecs[7]  = '{1'b0, 1'b1, DM_HALF_U, 32'h22, 32'h0,         32'h0000_BEEF};
      vecs[8]  = '{1'b1, 1'b1, DM_WORD,   32'h30, 32'hDEAD_BEEF, 32'h0};
      vecs[9]  = '{1'b0, 1'b1, DM_WORD,   32'h30, 32'h0,         32'hDEAD_BEEF};
      vecs[10] = '{1'b0, 1'b1, DM_BYTE,   32'h33, 32'h0,         32'hFFFF_FFDE};
      vecs[11] = '{1'b0, 1'b1, DM_BYTE_U, 32'h30, 32'h0,         32'h0000_00EF};
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].w, vecs[i].r, vecs[i].t, vecs[i].a, vecs[i].d, g);
         checkOutput($sformatf("vec%0d", i), g, vecs[i].exp);
      end
      checkOutput("no_err_legal", {31'h0, err}, 32'h0);

      // Timer: CMP=5 written while COUNT=2, match lands on the edge where COUNT is 5.
      doReset();
      applyStimulus(1'b0, 1'b1, DM_WORD, MMIO, 32'h0, g);
      checkOutput("count0", g, 32'h0);
      applyStimulus(1'b0, 1'b1, DM_WORD, MMIO, 32'h0, g);
      checkOutput("count1", g, 32'h1);
      applyStimulus(1'b1, 1'b0, DM_WORD, MMIO + 32'h4, 32'h5, g);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         irqSeq[2-i] = irq_timer;
      end
      checkOutput("irq_rise_at5", {29'h0, irqSeq}, 32'h1);
      applyStimulus(1'b1, 1'b0, DM_WORD, MMIO + 32'h8, 32'h1, g);
      checkOutput("w1c_clear", {31'h0, irq_timer}, 32'h0);
      c = countM;
      applyStimulus(1'b1, 1'b0, DM_WORD, MMIO + 32'h4, c + 32'd2, g);
      idle(1);
      applyStimulus(1'b1, 1'b0, DM_WORD, MMIO + 32'h8, 32'h1, g);
      checkOutput("set_beats_clear", {31'h0, irq_timer}, 32'h1);
      applyStimulus(1'b0, 1'b1, DM_WORD, MMIO + 32'h8, 32'h0, g);
      checkOutput("status_read", g, 32'h1);

      // Counter wrap and read-only COUNT.
      force u_dut.u_timer.r_count = 32'hFFFF_FFFF;
      #1;
      release u_dut.u_timer.r_count;
      countM = 32'hFFFF_FFFF;
      applyStimulus(1'b0, 1'b1, DM_WORD, MMIO, 32'h0, g);
      checkOutput("count_max", g, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b1, DM_WORD, MMIO, 32'h0, g);
      checkOutput("count_wrap", g, 32'h0);
      applyStimulus(1'b1, 1'b0, DM_WORD, MMIO, 32'h5555_5555, g);
      applyStimulus(1'b0, 1'b1, DM_WORD, MMIO, 32'h0, g);
      checkOutput("count_ro", g, 32'h2);
      checkOutput("wrap_no_err", {31'h0, err}, 32'h0);

      // Misaligned and unmapped accesses.
      doReset();
      applyStimulus(1'b1, 1'b0, DM_WORD, 32'h22, 32'hCAFE_F00D, g);
      checkOutput("misaligned_sw_err", {31'h0, err}, 32'h1);
      applyStimulus(1'b0, 1'b1, DM_WORD, 32'h20, 32'h0, g);
      checkOutput("mem_unchanged", g, 32'hBEEF_AB44);
      applyStimulus(1'b0, 1'b1, DM_WORD, 32'h0001_0000, 32'h0, g);
      checkOutput("unmapped_lw", g, 32'h0);
      applyStimulus(1'b0, 1'b1, DM_HALF, 32'h21, 32'h0, g);
      checkOutput("misaligned_lh", g, 32'h0);
      applyStimulus(1'b0, 1'b1, DM_BYTE, MMIO + 32'hC, 32'h0, g);
      checkOutput("mmio_subword", g, 32'h0);

      // Randomized traffic over RAM, the MMIO page and unmapped space.
      doReset();
      for (int i = 0; i < 400; i++) begin
         if (i == 200) doReset();
         cat = int'($urandom_range(0, 9));
         if (cat < 7)       ra = 32'($urandom_range(0, 255));
         else if (cat < 9)  ra = MMIO + 32'($urandom_range(0, 15));
         else               ra = 32'h0000_1000 + 32'($urandom_range(0, 4095));
         applyStimulus(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), ra, $urandom, g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
